mac_accum_pipe: RTL and testbench

- Parametrised, pipelined multiply-accumulate engine.
- Successor to the single-width free-running MAC.
- Accepts a stream of (k, l) operand pairs with a valid qualifier and accumulates fixed-length frames of LEN products (dot product).
- Emits one result per frame with a valid pulse and overflow flag; supports signed/unsigned operands and optional saturation.
- Sits between sample sources and downstream filter/statistics logic.

---
 rtl/mac_accum_pipe_pkg.sv | 28 ++
 rtl/mac_accum_pipe_sat_add.sv | 39 +++
 rtl/mac_accum_pipe.sv | 115 +++++++++++
 tb/tb_mac_accum_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_accum_pipe_pkg.sv
// Shared sizing helpers and saturation limits for the pipelined MAC.
// The limit functions return 64-bit patterns; callers truncate them to their own width.
package mac_pkg;

   localparam int unsigned LIM_W = 64;

   function automatic int unsigned cnt_width(input int unsigned len);
      return (len > 1) ? $clog2(len) : 1;
   endfunction

   function automatic logic [LIM_W-1:0] umax(input int unsigned w);
      return {LIM_W{1'b1}} >> (LIM_W - w);
   endfunction

   function automatic logic [LIM_W-1:0] smax(input int unsigned w);
      return {LIM_W{1'b1}} >> (LIM_W - w + 1);
   endfunction

   function automatic logic [LIM_W-1:0] smin(input int unsigned w);
      return {{(LIM_W-1){1'b0}}, 1'b1} << (w - 1);
   endfunction

   function automatic bit params_ok(input int unsigned in_w, input int unsigned acc_w,
                                    input int unsigned len);
      return (acc_w >= 2 * in_w) && (len >= 1);
   endfunction

endpackage

// File: rtl/mac_accum_pipe_sat_add.sv
// Combinational accumulate step: extends the product, adds it to the base,
// flags overflow and optionally clamps to the representable range.
module sat_add
   import mac_pkg::*;
#(
   parameter int unsigned W  = 22,
   parameter int unsigned PW = 20
) (
   input  logic [W-1:0]  a,
   input  logic [PW-1:0] b,
   input  logic          signed_mode,
   input  logic          sat_en,
   output logic [W-1:0]  sum,
   output logic          ovf
);

   localparam logic [W-1:0] UMAX = W'(umax(W));
   localparam logic [W-1:0] SMAX = W'(smax(W));
   localparam logic [W-1:0] SMIN = W'(smin(W));

   logic [W:0] ea;
   logic [W:0] eb;
   logic [W:0] s;

   always_comb begin
      ea  = {signed_mode & a[W-1], a};
      eb  = {{(W+1-PW){signed_mode & b[PW-1]}}, b};
      s   = ea + eb;
      sum = s[W-1:0];
      // Signed overflow: both addends share a sign that the truncated result lost.
      if (signed_mode) ovf = (a[W-1] == eb[W-1]) && (s[W-1] != a[W-1]);
      else             ovf = s[W];
      if (ovf && sat_en) begin
         if (signed_mode) sum = a[W-1] ? SMIN : SMAX;
         else             sum = UMAX;
      end
   end

endmodule

// File: rtl/mac_accum_pipe.sv
// Pipelined framed multiply-accumulate: P1 registers the product, stage A
// accumulates LEN products and pulses out_valid with the frame result.
module mac_accum_pipe
   import mac_pkg::*;
#(
   parameter int unsigned IN_W  = 10,
   parameter int unsigned ACC_W = 22,
   parameter int unsigned LEN   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  k,
   input  logic [IN_W-1:0]  l,
   input  logic             signed_mode,
   input  logic             sat_en,
   output logic [ACC_W-1:0] o,
   output logic             out_valid,
   output logic             ovf
);

   localparam int unsigned CNT_W = cnt_width(LEN);
   localparam int unsigned PW    = 2 * IN_W;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

   if (!params_ok(IN_W, ACC_W, LEN)) begin : g_bad_params
      $error("mac_accum_pipe: need ACC_W >= 2*IN_W and LEN >= 1");
   end

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [PW-1:0]    ka;
   logic [PW-1:0]    lb;
   logic [PW-1:0]    prod_r;
   logic             p_valid;
   logic             p_first;
   logic             p_last;
   logic             p_mode;
   logic             p_sat;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] base;
   logic [ACC_W-1:0] step_sum;
   logic             step_ovf;
   logic             out_valid_r;
   logic             ovf_r;

   // Extending per mode before one PW-bit multiply gives the correct signed or unsigned low half.
   always_comb begin
      ka      = {{IN_W{signed_mode & k[IN_W-1]}}, k};
      lb      = {{IN_W{signed_mode & l[IN_W-1]}}, l};
      cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
      base    = p_first ? '0 : acc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         prod_r  <= '0;
         p_valid <= 1'b0;
         p_first <= 1'b0;
         p_last  <= 1'b0;
         p_mode  <= 1'b0;
         p_sat   <= 1'b0;
      end else if (clr) begin
         cnt     <= '0;
         p_valid <= 1'b0;
      end else begin
         p_valid <= in_valid;
         if (in_valid) begin
            prod_r  <= ka * lb;
            p_first <= (cnt == '0);
            p_last  <= (cnt == LAST);
            p_mode  <= signed_mode;
            p_sat   <= sat_en;
            cnt     <= cnt_nxt;
         end
      end
   end

   sat_add #(
      .W  (ACC_W),
      .PW (PW)
   ) u_sat_add (
      .a           (base),
      .b           (prod_r),
      .signed_mode (p_mode),
      .sat_en      (p_sat),
      .sum         (step_sum),
      .ovf         (step_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc         <= '0;
         out_valid_r <= 1'b0;
         ovf_r       <= 1'b0;
      end else if (clr) begin
         acc         <= '0;
         out_valid_r <= 1'b0;
         ovf_r       <= 1'b0;
      end else begin
         out_valid_r <= p_valid & p_last;
         if (p_valid) begin
            acc   <= step_sum;
            ovf_r <= step_ovf | (ovf_r & ~p_first);
         end
      end
   end

   assign o         = acc;
   assign out_valid = out_valid_r;
   assign ovf       = ovf_r;

endmodule

// File: tb/tb_mac_accum_pipe.sv
// Scoreboard bench: three MAC instances (LEN 4, 8, 1) share one input stream;
// a reference model pushes expected frame results, monitors pop them on out_valid.
module tb_mac_accum_pipe;

   localparam int IN_W  = 10;
   localparam int ACC_W = 22;
   localparam longint SPAN = 64'd1 << ACC_W;

   typedef struct {
      logic [ACC_W-1:0] o;
      logic             ovf;
      int               due;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            clr = 1'b0;
   logic            in_valid = 1'b0;
   logic [IN_W-1:0] k = '0;
   logic [IN_W-1:0] l = '0;
   logic            signed_mode = 1'b0;
   logic            sat_en = 1'b0;

   logic [ACC_W-1:0] o_w   [3];
   logic             ov_w  [3];
   logic             ovf_w [3];

   int               lens [3] = '{4, 8, 1};
   int               m_cnt [3];
   logic [ACC_W-1:0] m_acc [3];
   logic             m_ovf [3];
   exp_t             q [3][$];

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mac_accum_pipe #(.IN_W(IN_W), .ACC_W(ACC_W), .LEN(4)) u_len4 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .k(k), .l(l),
      .signed_mode(signed_mode), .sat_en(sat_en),
      .o(o_w[0]), .out_valid(ov_w[0]), .ovf(ovf_w[0]));

   mac_accum_pipe #(.IN_W(IN_W), .ACC_W(ACC_W), .LEN(8)) u_len8 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .k(k), .l(l),
      .signed_mode(signed_mode), .sat_en(sat_en),
      .o(o_w[1]), .out_valid(ov_w[1]), .ovf(ovf_w[1]));

   mac_accum_pipe #(.IN_W(IN_W), .ACC_W(ACC_W), .LEN(1)) u_len1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .k(k), .l(l),
      .signed_mode(signed_mode), .sat_en(sat_en),
      .o(o_w[2]), .out_valid(ov_w[2]), .ovf(ovf_w[2]));

   task automatic check_val(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_sample(input logic [IN_W-1:0] kk, input logic [IN_W-1:0] ll,
                               input logic sm, input logic se, input int now);
      for (int i = 0; i < 3; i++) begin
         longint pk, pl, base, sum, hi, lo;
         pk = kk;
         if (sm && kk[IN_W-1]) pk -= (64'd1 << IN_W);
         pl = ll;
         if (sm && ll[IN_W-1]) pl -= (64'd1 << IN_W);
         if (m_cnt[i] == 0) begin
            base = 0;
            m_ovf[i] = 1'b0;
         end else begin
            base = m_acc[i];
            if (sm && m_acc[i][ACC_W-1]) base -= SPAN;
         end
         sum = base + pk * pl;
         hi = sm ? SPAN / 2 - 1 : SPAN - 1;
         lo = sm ? -(SPAN / 2) : 0;
         if (sum > hi) begin
            m_ovf[i] = 1'b1;
            sum = se ? hi : sum - SPAN;
         end else if (sum < lo) begin
            m_ovf[i] = 1'b1;
            sum = se ? lo : sum + SPAN;
         end
         m_acc[i] = sum[ACC_W-1:0];
         m_cnt[i]++;
         if (m_cnt[i] == lens[i]) begin
            q[i].push_back('{o: m_acc[i], ovf: m_ovf[i], due: now + 2});
            m_cnt[i] = 0;
         end
      end
   endtask

   // Forget partial frames and any result due at or after cycle thr.
   task automatic model_flush(input int thr);
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0;
         m_acc[i] = '0;
         m_ovf[i] = 1'b0;
         while (q[i].size() > 0 && q[i][q[i].size()-1].due >= thr) void'(q[i].pop_back());
      end
   endtask

   task automatic send(input int kk, input int ll, input logic sm, input logic se);
      @(posedge clk);
      #1;
      in_valid    = 1'b1;
      k           = kk[IN_W-1:0];
      l           = ll[IN_W-1:0];
      signed_mode = sm;
      sat_en      = se;
      model_sample(k, l, sm, se, cyc);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic frame_a();
      send(3, 6, 1'b0, 1'b0);
      send(4, 7, 1'b0, 1'b0);
      send(5, 8, 1'b0, 1'b0);
      send(1, 1, 1'b0, 1'b0);
   endtask

   task automatic check_zero(input string tag);
      for (int i = 0; i < 3; i++) begin
         check_val($sformatf("%s_o%0d", tag, i), o_w[i], 0);
         check_val($sformatf("%s_valid%0d", tag, i), ov_w[i], 0);
         check_val($sformatf("%s_ovf%0d", tag, i), ovf_w[i], 0);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 3; i++) begin
            if (ov_w[i]) begin
               if (q[i].size() == 0) begin
                  check_val($sformatf("spurious_valid%0d", i), 1, 0);
               end else begin
                  exp_t e;
                  e = q[i].pop_front();
                  check_val($sformatf("o_len%0d", lens[i]), o_w[i], e.o);
                  check_val($sformatf("ovf_len%0d", lens[i]), ovf_w[i], e.ovf);
                  check_val($sformatf("lat_len%0d", lens[i]), cyc, e.due);
               end
            end
         end
      end
   end

   initial begin
      model_flush(0);
      #2;
      check_zero("reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Basic unsigned frame, then the same with bubbles followed directly by (2,2)x4.
      frame_a();
      idle(4);
      send(3, 6, 1'b0, 1'b0); idle(1);
      send(4, 7, 1'b0, 1'b0); idle(3);
      send(5, 8, 1'b0, 1'b0); idle(2);
      send(1, 1, 1'b0, 1'b0);
      repeat (4) send(2, 2, 1'b0, 1'b0);
      idle(4);

      // clr after two samples, with a sample on the clr cycle that must be dropped.
      send(3, 6, 1'b0, 1'b0);
      send(4, 7, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      clr = 1'b1;
      in_valid = 1'b1;
      k = 10'd9;
      l = 10'd9;
      model_flush(cyc + 1);
      @(posedge clk);
      #1;
      clr = 1'b0;
      in_valid = 1'b0;
      check_zero("clr");
      frame_a();
      idle(4);

      // Realign the LEN=8 instance before the overflow frames.
      @(posedge clk);
      #1;
      clr = 1'b1;
      model_flush(cyc + 1);
      @(posedge clk);
      #1;
      clr = 1'b0;

      repeat (8) send(1023, 1023, 1'b0, 1'b1);
      repeat (8) send(1023, 1023, 1'b0, 1'b0);
      repeat (8) send(-512, -512, 1'b1, 1'b1);
      repeat (8) send(-512, -512, 1'b1, 1'b0);
      idle(4);

      repeat (2) begin
         send(-3, 6, 1'b1, 1'b0);
         send(4, -7, 1'b1, 1'b0);
         send(5, 8, 1'b1, 1'b0);
         send(-1, -1, 1'b1, 1'b0);
      end
      idle(4);

      // Asynchronous reset between edges in the middle of a frame.
      send(3, 6, 1'b0, 1'b0);
      send(4, 7, 1'b0, 1'b0);
      #3;
      in_valid = 1'b0;
      rst_n = 1'b0;
      model_flush(cyc);
      #1;
      check_zero("rst_mid");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      frame_a();
      idle(4);

      repeat (40) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         else send($urandom_range(0, 1023), $urandom_range(0, 1023),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      idle(10);

      for (int i = 0; i < 3; i++)
         check_val($sformatf("pending_len%0d", lens[i]), q[i].size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
